pixel_plot_buffer: RTL

PIXEL_PLOT_BUFFER -- requirements
Module: pixel_plot_buffer

---
 rtl/vga_pkg.sv | 39 +++
 rtl/pixel_plot_buffer_if.sv | 36 +++
 rtl/pixel_fifo.sv | 66 ++++++
 rtl/pixel_plot_buffer.sv | 110 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA screen limits, coordinate types and buffer state encoding.
// No ports; imported by the pixel plot buffer, its FIFO and its interface.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int IN_XW    = 9;
  localparam int IN_YW    = 8;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;

  typedef logic signed [IN_XW-1:0] in_x_t;
  typedef logic signed [IN_YW-1:0] in_y_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  function automatic logic on_screen(
    input in_x_t x,
    input in_y_t y
  );
    return !x[IN_XW-1]
      && (x <= in_x_t'(SCREEN_W - 1))
      && !y[IN_YW-1]
      && (y <= in_y_t'(SCREEN_H - 1));
  endfunction

endpackage

// File: rtl/pixel_plot_buffer_if.sv
// Pixel stream in from drawing engines, plot stream out to the VGA adapter.
// master: drawing side + adapter side; slave: the buffer.
interface pixel_plot_buffer_if;
  import vga_pkg::*;

  logic          in_valid;
  logic          in_ready;
  in_x_t         in_x;
  in_y_t         in_y;
  logic [CW-1:0] in_colour;
  logic          in_last;
  logic          out_ready;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;
  logic          done;
  logic [15:0]   clip_count;

  modport master (
    output in_valid, in_x, in_y,
    output in_colour, in_last, out_ready,
    input  in_ready, vga_x, vga_y,
    input  vga_colour, vga_plot,
    input  done, clip_count
  );

  modport slave (
    input  in_valid, in_x, in_y,
    input  in_colour, in_last, out_ready,
    output in_ready, vga_x, vga_y,
    output vga_colour, vga_plot,
    output done, clip_count
  );

endinterface

// File: rtl/pixel_fifo.sv
// Pixel FIFO: sync-write memory, pointers, registered head/plot outputs.
// Ports: push_i/wdata_i, pop_i in; head_o, plot_o, count_o, wptr_o, rptr_o out.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  pix_t          wdata_i,
  input  logic          pop_i,
  output pix_t          head_o,
  output logic          plot_o,
  output logic [AW:0]   count_o,
  output logic [AW-1:0] wptr_o,
  output logic [AW-1:0] rptr_o
);

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   left;
  pix_t          head_q, head_d;
  logic          plot_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(push_i);
    rptr_d  = rptr_q + AW'(pop_i);
    left    = count_q - (AW+1)'(pop_i);
    count_d = left + (AW+1)'(push_i);
    head_d  = '0;
    // nothing left after the pop: the word being written is the new head
    if (count_d != '0)
      head_d = (left == '0) ? wdata_i : mem_q[rptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      plot_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      plot_q  <= (count_d != '0);
    end
  end

  assign head_o  = head_q;
  assign plot_o  = plot_q;
  assign count_o = count_q;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;

endmodule

// File: rtl/pixel_plot_buffer.sv
// Clips, queues and plays out pixels to the VGA adapter; pulses done per drawing.
// Ports: clk, rst_n (async, active low), bus (pixel_plot_buffer_if.slave).
module pixel_plot_buffer
  import vga_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  pixel_plot_buffer_if.slave  bus
);

  logic [AW:0]   occ, occ_after, occ_next;
  logic [AW-1:0] wptr, rptr;
  logic [AW-1:0] pend_idx_q, pend_idx_d;
  logic [15:0]   clip_q, clip_d;
  state_e        state_q, state_d;
  logic          ready_en_q;
  logic          in_ready, accept, push, pop;
  logic          clipped, hold_last, done_evt;
  logic          plot;
  pix_t          head, wdata;

  assign clipped   = !on_screen(bus.in_x, bus.in_y);
  // a second drawing end waits until the current one has signalled done
  assign hold_last = bus.in_last
    && (state_q == S_FLUSH || state_q == S_DONE);
  assign in_ready  = ready_en_q
    && (occ < (AW+1)'(DEPTH)) && !hold_last;
  assign accept    = bus.in_valid && in_ready;
  assign push      = accept && !clipped;
  assign pop       = plot && bus.out_ready;
  assign occ_after = occ - (AW+1)'(pop);
  assign occ_next  = occ_after + (AW+1)'(push);

  assign wdata = '{
    x: bus.in_x[XW-1:0],
    y: bus.in_y[YW-1:0],
    c: bus.in_colour
  };

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .plot_o  (plot),
    .count_o (occ),
    .wptr_o  (wptr),
    .rptr_o  (rptr)
  );

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    clip_d     = clip_q;
    done_evt   = 1'b0;
    if (accept && clipped && clip_q != 16'hFFFF)
      clip_d = clip_q + 16'd1;
    if (state_q == S_FLUSH && pop && rptr == pend_idx_q)
      done_evt = 1'b1;
    if (accept && bus.in_last && clipped && occ_after == '0)
      done_evt = 1'b1;
    unique case (state_q)
      S_FLUSH: begin
        if (done_evt) state_d = S_DONE;
      end
      S_IDLE, S_STREAM, S_DONE: begin
        if (done_evt) begin
          state_d = S_DONE;
        end else if (accept && bus.in_last) begin
          state_d = S_FLUSH;
          // clipped end marker tracks the newest stored entry
          pend_idx_d = clipped ? wptr - AW'(1) : wptr;
        end else if (occ_next != '0) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_idx_q <= '0;
      clip_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      clip_q     <= clip_d;
      ready_en_q <= 1'b1;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.vga_x      = head.x;
  assign bus.vga_y      = head.y;
  assign bus.vga_colour = head.c;
  assign bus.vga_plot   = plot;
  assign bus.done       = (state_q == S_DONE);
  assign bus.clip_count = clip_q;

endmodule
